sponge_absorb_packer: RTL and testbench
=======================================

SPONGE_ABSORB_PACKER -- requirements
Module: sponge_absorb_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64, input beat width in bits; a multiple of 8.
REQ-002 SHALL have parameter RATE_WIDTH, default 256, sponge rate block width in bits; a multiple of IN_WIDTH.
REQ-003 SHALL have parameter PAD_BEGINNING, default 'h1f, domain-separation pad byte.
REQ-004 SHALL have parameter PAD_ENDING, default 'h80, final pad byte.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-006 SHALL have port clear_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port in_data, input, IN_WIDTH, message beat; byte k at bits [8k+7:8k], byte 0 first in message order.
REQ-008 SHALL have port in_valid, input, 1, beat present.
REQ-009 SHALL have port in_last, input, 1, beat ends the message.
REQ-010 SHALL have port in_nbytes, input, $clog2(IN_WIDTH/8)+1, count of valid low bytes of a last beat, 0..IN_WIDTH/8; ignored when in_last=0, when all bytes are valid.
REQ-011 SHALL have port in_ready, output, 1, beat accepted when in_valid & in_ready.
REQ-012 SHALL have port out_block, output, RATE_WIDTH, block; message byte i of the block at bits [8i+7:8i].
REQ-013 SHALL have port out_valid, output, 1, block present.
REQ-014 SHALL have port out_last, output, 1, block is the final padded block.
REQ-015 SHALL have port out_ready, input, 1, block consumed when out_valid & out_ready.

Function
REQ-016 SHALL implement the FSM states FILL, PAD, HOLD; RB = RATE_WIDTH/8 is the block byte count; byte pointer ptr runs 0..RB.
REQ-017 SHALL drive in_ready=1 only in FILL; SHALL drive in_ready=0 in PAD and HOLD.
REQ-018 SHALL, on an accepted non-last beat, write IN_WIDTH/8 bytes at ptr and advance ptr; at ptr==RB it SHALL enter HOLD with out_last=0.
REQ-019 SHALL, on an accepted last beat with ptr+in_nbytes<RB, write the data bytes, PAD_BEGINNING at byte ptr+in_nbytes, zeros up to byte RB-1, OR PAD_ENDING into byte RB-1, then enter HOLD with out_last=1.
REQ-020 SHALL, when PAD_BEGINNING falls on byte RB-1, make that byte PAD_BEGINNING|PAD_ENDING (0x9F by default).
REQ-021 SHALL, on an accepted last beat that fills the block exactly (ptr+in_nbytes==RB), enter HOLD with out_last=0, then PAD after handshake.
REQ-022 SHALL, in PAD, build block {byte0=PAD_BEGINNING, zeros, byte RB-1=PAD_ENDING} in one cycle, then enter HOLD with out_last=1.
REQ-023 SHALL assert out_valid exactly in HOLD, first the cycle after the completing beat or the PAD cycle; latency is 1 cycle.
REQ-024 SHALL keep out_block and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, on the HOLD handshake, clear the buffer, set ptr=0, and go to PAD if pending, else to FILL; in_ready rises in the next cycle (no bypass).
REQ-026 SHALL treat in_last with in_nbytes=0 at ptr=0 as an empty-message terminator, producing a padding-only final block.
REQ-027 SHALL hold an unused in_nbytes>IN_WIDTH/8 as undefined; no checking is required.

Reset
REQ-028 SHALL, while clear_n=0, force state=FILL, ptr=0, buffer=0, out_block=0, out_valid=0, out_last=0, in_ready=0.
REQ-029 SHALL drive in_ready=1 on the first clk edge after clear_n deasserts.
REQ-030 SHALL discard a partial message on reset mid-operation; no block for it is ever emitted.

Verification (IN_WIDTH=64, RATE_WIDTH=256, RB=32)
REQ-031 Empty message (in_last=1, in_nbytes=0) -> one block, byte0=0x1F, bytes1..30=0, byte31=0x80, out_last=1.
REQ-032 Last beat with bytes 01 02 03 (in_nbytes=3) -> bytes0..2=01,02,03, byte3=0x1F, byte31=0x80, out_last=1, out_valid 1 cycle after acceptance.
REQ-033 31-byte message (3 full beats + 7-byte last) -> single block, byte31=0x9F, out_last=1.
REQ-034 32-byte message (4 full beats, last beat in_nbytes=8) -> block0 = data with out_last=0; after handshake, block1 = 0x1F..0x80 with out_last=1.
REQ-035 Two-block 40-byte message with out_ready low 5 cycles on block0 -> out_block stable, in_ready=0 throughout, no beats lost, block1 correct.
REQ-036 clear_n pulsed low after 2 beats, then 3-byte message -> only the 3-byte padded block is emitted, matching REQ-032.

Source files
------------

// File: rtl/sponge_absorb_packer.sv
// Sponge absorb packer: gathers message beats into rate-sized blocks
// and appends the pad10*1-style domain padding on the final block.
module sponge_absorb_packer #(
    parameter int           IN_WIDTH      = 64,
    parameter int           RATE_WIDTH    = 256,
    parameter logic [7:0]   PAD_BEGINNING = 8'h1f,
    parameter logic [7:0]   PAD_ENDING    = 8'h80
) (
    input  logic                            clk,
    input  logic                            clear_n,
    input  logic [IN_WIDTH-1:0]             in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    input  logic [$clog2(IN_WIDTH/8):0]     in_nbytes,
    output logic                            in_ready,
    output logic [RATE_WIDTH-1:0]           out_block,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready
);

    localparam int BB = IN_WIDTH / 8;
    localparam int RB = RATE_WIDTH / 8;
    localparam int PW = $clog2(RB + 1);

    typedef enum logic [1:0] {
        FILL,
        PAD,
        HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [RATE_WIDTH-1:0]  buf_q, buf_d;
    logic [RATE_WIDTH-1:0]  beat_blk, pad_blk;
    logic                   last_q, last_d;
    logic                   pend_q, pend_d;
    logic                   rdy_q, rdy_d;
    logic                   accept;
    logic                   fits;
    int                     p, n;

    // Merge the incoming beat (and any padding it triggers) into the buffer.
    always_comb begin
        p        = int'(ptr_q);
        n        = in_last ? int'(in_nbytes) : BB;
        fits     = (p + n) < RB;
        beat_blk = buf_q;
        for (int i = 0; i < RB; i++) begin
            for (int k = 0; k < BB; k++) begin
                if (i == p + k && k < n) begin
                    beat_blk[8*i +: 8] = in_data[8*k +: 8];
                end
            end
            if (in_last && i == p + n) begin
                beat_blk[8*i +: 8] = PAD_BEGINNING;
            end
            if (in_last && fits && i == RB - 1) begin
                beat_blk[8*i +: 8] = beat_blk[8*i +: 8] | PAD_ENDING;
            end
        end
    end

    always_comb begin
        pad_blk                       = '0;
        pad_blk[7:0]                  = PAD_BEGINNING;
        pad_blk[RATE_WIDTH-1 -: 8]    = pad_blk[RATE_WIDTH-1 -: 8] | PAD_ENDING;
    end

    assign accept = in_valid & rdy_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        buf_d   = buf_q;
        last_d  = last_q;
        pend_d  = pend_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d = beat_blk;
                    if (in_last) begin
                        ptr_d   = '0;
                        state_d = HOLD;
                        last_d  = fits;
                        pend_d  = !fits;
                    end else begin
                        ptr_d = ptr_q + PW'(BB);
                        if (p + BB >= RB) begin
                            state_d = HOLD;
                            last_d  = 1'b0;
                        end
                    end
                end
            end
            PAD: begin
                buf_d   = pad_blk;
                last_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    buf_d   = '0;
                    ptr_d   = '0;
                    last_d  = 1'b0;
                    pend_d  = 1'b0;
                    state_d = pend_q ? PAD : FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // in_ready is registered so it cannot rise combinationally off a handshake.
    assign rdy_d = (state_d == FILL);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= FILL;
            ptr_q   <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_block = buf_q;
    assign out_valid = (state_q == HOLD);
    assign out_last  = last_q;

endmodule

// File: tb/tb_sponge_absorb_packer.sv
// Bench for sponge_absorb_packer: table of messages, padding model
// scoreboard, output stalls and a mid-message clear.
module tb_sponge_absorb_packer;

    localparam int IW = 64;
    localparam int RW = 256;
    localparam int BB = IW / 8;
    localparam int RB = RW / 8;
    localparam logic [7:0] PB = 8'h1f;
    localparam logic [7:0] PE = 8'h80;

    logic                  clk = 1'b0;
    logic                  clear_n;
    logic [IW-1:0]         in_data;
    logic                  in_valid;
    logic                  in_last;
    logic [$clog2(BB):0]   in_nbytes;
    logic                  in_ready;
    logic [RW-1:0]         out_block;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    sponge_absorb_packer #(
        .IN_WIDTH(IW),
        .RATE_WIDTH(RW),
        .PAD_BEGINNING(PB),
        .PAD_ENDING(PE)
    ) dut (
        .clk(clk),
        .clear_n(clear_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_nbytes(in_nbytes),
        .in_ready(in_ready),
        .out_block(out_block),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] blk;
        logic          last;
    } exp_t;

    typedef struct {
        int         len;
        int         seed;
        int         stall;
        int         nblk;
        logic [7:0] b0;
        logic [7:0] b31;
    } vec_t;

    exp_t          exp_q[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            stall_left = 0;
    int            blocks_seen = 0;
    logic [RW-1:0] last_blk = '0;
    logic [RW-1:0] held;
    logic          held_last;
    logic          holding = 1'b0;

    task automatic check(input string name, input logic [RW-1:0] got,
                         input logic [RW-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference padding: msg || PB || 0* || PE, split into rate blocks.
    task automatic push_expected(input int len, input int seed);
        logic [7:0] m[$];
        exp_t       e;
        int         nb;
        for (int j = 0; j < len; j++) m.push_back(8'(j + 1 + seed));
        m.push_back(PB);
        while (m.size() % RB != 0) m.push_back(8'h00);
        m[m.size()-1] = m[m.size()-1] | PE;
        nb = m.size() / RB;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int i = 0; i < RB; i++) e.blk[8*i +: 8] = m[b*RB + i];
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input logic l,
                             input int cnt);
        int t;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        in_nbytes = ($clog2(BB)+1)'(cnt);
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("beat_accept", RW'(in_ready), RW'(1));
    endtask

    task automatic send_msg(input int len, input int seed);
        int            nbeats, cnt;
        logic          l;
        logic [IW-1:0] d;
        nbeats = (len <= BB) ? 1 : (len - 1) / BB + 1;
        for (int b = 0; b < nbeats; b++) begin
            l   = (b == nbeats - 1);
            cnt = l ? len - b * BB : BB;
            for (int k = 0; k < BB; k++)
                d[8*k +: 8] = (k < cnt) ? 8'(b*BB + k + 1 + seed) : 8'hee;
            send_beat(d, l, cnt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("latency_out_valid", RW'(out_valid), RW'(1));
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", RW'(exp_q.size()), RW'(0));
    endtask

    // Output side: optional stall, stability and scoreboard compare.
    initial begin
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (clear_n && out_valid) begin
                check("in_ready_low_in_hold", RW'(in_ready), RW'(0));
                if (stall_left > 0) begin
                    if (!holding) begin
                        held      = out_block;
                        held_last = out_last;
                        holding   = 1'b1;
                    end else begin
                        check("stall_block_stable", out_block, held);
                        check("stall_last_stable", RW'(out_last),
                              RW'(held_last));
                    end
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    holding   = 1'b0;
                    out_ready = 1'b1;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_block: got %h want none",
                                 out_block);
                    end else begin
                        e = exp_q.pop_front();
                        check("block", out_block, e.blk);
                        check("block_last", RW'(out_last), RW'(e.last));
                        blocks_seen++;
                        last_blk = out_block;
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        vec_t vecs[10];
        int   start;
        vecs[0] = '{len: 0,  seed: 0,  stall: 0, nblk: 1, b0: 8'h1f, b31: 8'h80};
        vecs[1] = '{len: 3,  seed: 0,  stall: 0, nblk: 1, b0: 8'h01, b31: 8'h80};
        vecs[2] = '{len: 31, seed: 0,  stall: 0, nblk: 1, b0: 8'h01, b31: 8'h9f};
        vecs[3] = '{len: 32, seed: 0,  stall: 0, nblk: 2, b0: 8'h1f, b31: 8'h80};
        vecs[4] = '{len: 40, seed: 16, stall: 5, nblk: 2, b0: 8'h31, b31: 8'h80};
        vecs[5] = '{len: 8,  seed: 3,  stall: 0, nblk: 1, b0: 8'h04, b31: 8'h80};
        vecs[6] = '{len: 24, seed: 0,  stall: 1, nblk: 1, b0: 8'h01, b31: 8'h80};
        vecs[7] = '{len: 63, seed: 0,  stall: 2, nblk: 2, b0: 8'h21, b31: 8'h9f};
        vecs[8] = '{len: 64, seed: 0,  stall: 3, nblk: 3, b0: 8'h1f, b31: 8'h80};
        vecs[9] = '{len: 17, seed: 99, stall: 0, nblk: 1, b0: 8'h64, b31: 8'h80};

        clear_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        in_nbytes = '0;
        #1;
        check("rst_in_ready", RW'(in_ready), RW'(0));
        check("rst_out_valid", RW'(out_valid), RW'(0));
        check("rst_out_last", RW'(out_last), RW'(0));
        check("rst_out_block", out_block, '0);
        repeat (3) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", RW'(in_ready), RW'(1));

        for (int v = 0; v < 10; v++) begin
            start      = blocks_seen;
            stall_left = vecs[v].stall;
            push_expected(vecs[v].len, vecs[v].seed);
            send_msg(vecs[v].len, vecs[v].seed);
            drain();
            check("nblk", RW'(blocks_seen - start), RW'(vecs[v].nblk));
            check("final_b0", RW'(last_blk[7:0]), RW'(vecs[v].b0));
            check("final_b31", RW'(last_blk[RW-1 -: 8]), RW'(vecs[v].b31));
        end

        // Empty-message block, spelled out byte for byte.
        push_expected(0, 0);
        send_msg(0, 0);
        drain();
        check("empty_block_literal", last_blk, {8'h80, 240'h0, 8'h1f});

        // Partial message abandoned by a clear, then a 3-byte message.
        start = blocks_seen;
        send_beat({8{8'haa}}, 1'b0, BB);
        send_beat({8{8'hbb}}, 1'b0, BB);
        @(negedge clk);
        in_valid = 1'b0;
        clear_n  = 1'b0;
        #1;
        check("midrst_in_ready", RW'(in_ready), RW'(0));
        check("midrst_out_block", out_block, '0);
        check("midrst_out_valid", RW'(out_valid), RW'(0));
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_again", RW'(in_ready), RW'(1));
        push_expected(3, 0);
        send_msg(3, 0);
        drain();
        check("midrst_nblk", RW'(blocks_seen - start), RW'(1));
        check("three_byte_literal", last_blk,
              {8'h80, 216'h0, 8'h1f, 8'h03, 8'h02, 8'h01});

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
